// File: rtl/mmio_fifo_pkg.sv
// rtl/mmio_fifo_pkg.sv - register offsets, STATUS bit positions and STATUS layout for the MMIO FIFO window
package mmio_fifo_pkg;

    localparam logic [2:0] OFS_PUSH   = 3'd0;
    localparam logic [2:0] OFS_POP    = 3'd2;
    localparam logic [2:0] OFS_STATUS = 3'd4;
    localparam logic [2:0] OFS_CTRL   = 3'd6;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_OVF_BIT   = 18;
    localparam int ST_UNF_BIT   = 19;
    localparam int ST_DEPTH_LSB = 32;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_ERR_BIT = 1;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [15:0] depth;
        logic [11:0] rsvd_mid;
        logic        underflow_err;
        logic        overflow_err;
        logic        full;
        logic        empty;
        logic [15:0] count;
    } t_fifo_status;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage: one synchronous write port, one combinational read port, no reset
module fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// rtl/mmio_fifo_ctrl.sv - MMIO window decode turning PUSH/POP/STATUS/CTRL accesses into FIFO operations
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mmio_wr_valid,
    input  logic                       mmio_rd_valid,
    input  logic [15:0]                mmio_addr,
    input  logic [8:0]                 mmio_tid,
    input  logic [63:0]                mmio_wr_data,
    output logic                       rsp_valid,
    output logic [8:0]                 rsp_tid,
    output logic [63:0]                rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_full,
    output logic                       fifo_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [8:0]    rsp_tid_q, rsp_tid_d;
    logic [63:0]   rsp_data_q, rsp_data_d;

    logic          hit;
    logic [2:0]    ofs;
    logic          mem_we;
    logic [63:0]   mem_rdata;
    t_fifo_status  status;

    assign hit = (mmio_addr[15:3] == BASE_ADDR[15:3]);
    assign ofs = mmio_addr[2:0];

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (mmio_wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // STATUS is built from registered state, so it shows the pre-update view
    always_comb begin
        status               = '0;
        status.count         = 16'(count_q);
        status.empty         = empty_q;
        status.full          = full_q;
        status.overflow_err  = ovf_q;
        status.underflow_err = unf_q;
        status.depth         = 16'(DEPTH);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        rsp_valid_d = 1'b0;
        rsp_tid_d   = rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        mem_we      = 1'b0;

        if (mmio_wr_valid && hit) begin
            case (ofs)
                OFS_PUSH: begin
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + CW'(1);
                    end
                end
                OFS_CTRL: begin
                    if (mmio_wr_data[CTRL_FLUSH_BIT]) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end
                    if (mmio_wr_data[CTRL_CLR_ERR_BIT]) begin
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (mmio_rd_valid && hit) begin
            rsp_valid_d = 1'b1;
            rsp_tid_d   = mmio_tid;
            case (ofs)
                OFS_POP: begin
                    if (empty_q) begin
                        rsp_data_d = '0;
                        unf_d      = 1'b1;
                    end else begin
                        rsp_data_d = mem_rdata;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        count_d    = count_q - CW'(1);
                    end
                end
                OFS_STATUS: rsp_data_d = status;
                default:    rsp_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_tid    = rsp_tid_q;
    assign rsp_data   = rsp_data_q;
    assign fifo_count = count_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;

    // Write wins when both strobes arrive together; the read is silently dropped
    a_wr_rd_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mmio_wr_valid && mmio_rd_valid));

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb/tb_mmio_fifo_ctrl.sv - table-driven self-checking bench for mmio_fifo_ctrl
module tb_mmio_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wr_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    int checks = 0;
    int errors = 0;

    mmio_fifo_ctrl #(
        .DEPTH     (8),
        .DATA_W    (64),
        .BASE_ADDR (16'h0020)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wr_data  (mmio_wr_data),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] wdata;
        logic        ev;
        logic [63:0] ed;
        logic [3:0]  ec;
        logic        ef;
        logic        ee;
    } vec_t;

    localparam logic [63:0] ST_EMPTY0 = 64'h0000_0008_0001_0000;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] addr,
                                input logic [8:0] tid, input logic [63:0] wdata,
                                input logic ev, input logic [63:0] ed, input logic [3:0] ec,
                                input logic ef, input logic ee);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.tid = tid; v.wdata = wdata;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction per cycle; outputs sampled 1 time unit after the edge
    task automatic run_vec(input vec_t v, input string name);
        mmio_wr_valid = v.wr;
        mmio_rd_valid = v.rd;
        mmio_addr     = v.addr;
        mmio_tid      = v.tid;
        mmio_wr_data  = v.wdata;
        @(posedge clk);
        #1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        chk({name, "_valid"}, 64'(rsp_valid), 64'(v.ev));
        if (v.ev) begin
            chk({name, "_tid"},  64'(rsp_tid), 64'(v.tid));
            chk({name, "_data"}, rsp_data, v.ed);
        end
        chk({name, "_count"}, 64'(fifo_count), 64'(v.ec));
        chk({name, "_full"},  64'(fifo_full),  64'(v.ef));
        chk({name, "_empty"}, 64'(fifo_empty), 64'(v.ee));
    endtask

    initial begin
        rst = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_addr = '0;
        mmio_tid = '0;
        mmio_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_tid",   64'(rsp_tid),   64'd0);
        chk("rst_data",  rsp_data,       64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_full",  64'(fifo_full),  64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        rst = 1'b0;

        //                 wr    rd    addr      tid     wdata   ev    exp_data                  cnt  full empty
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h005, 64'h0,  1'b1, ST_EMPTY0,                4'd0, 0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'hA,  1'b0, 64'h0,                    4'd1, 0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'hB,  1'b0, 64'h0,                    4'd2, 0, 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'hC,  1'b0, 64'h0,                    4'd3, 0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0022, 9'h001, 64'h0,  1'b1, 64'hA,                    4'd2, 0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0022, 9'h002, 64'h0,  1'b1, 64'hB,                    4'd1, 0, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0022, 9'h003, 64'h0,  1'b1, 64'hC,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h007, 64'h0,  1'b1, ST_EMPTY0,                4'd0, 0, 1));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'(i), 1'b0, 64'h0, 4'(i), (i == 8), 0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'h9,  1'b0, 64'h0,                    4'd8, 1, 0));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h010, 64'h0,  1'b1, 64'h0000_0008_0006_0008,  4'd8, 1, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1'b0, 1'b1, 16'h0022, 9'(8'h40 + i), 64'h0, 1'b1, 64'(i), 4'(8 - i), 0, (i == 8)));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0022, 9'h1FF, 64'h0,  1'b1, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h020, 64'h0,  1'b1, 64'h0000_0008_000D_0000,  4'd0, 0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0026, 9'h000, 64'h2,  1'b0, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h021, 64'h0,  1'b1, ST_EMPTY0,                4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0020, 9'h011, 64'h0,  1'b1, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0026, 9'h012, 64'h0,  1'b1, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0022, 9'h000, 64'h55, 1'b0, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0024, 9'h000, 64'h55, 1'b0, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0040, 9'h013, 64'h0,  1'b0, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0040, 9'h000, 64'h77, 1'b0, 64'h0,                    4'd0, 0, 1));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0024, 9'h014, 64'h0,  1'b1, ST_EMPTY0,                4'd0, 0, 1));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            run_vec(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'h1000 + 64'(i), 1'b0, 64'h0, 4'd1, 0, 0),
                    $sformatf("wrap_push%0d", i));
            run_vec(mk(1'b0, 1'b1, 16'h0022, 9'(i), 64'h0, 1'b1, 64'h1000 + 64'(i), 4'd0, 0, 1),
                    $sformatf("wrap_pop%0d", i));
        end

        for (int i = 0; i < 5; i++)
            run_vec(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'hF0 + 64'(i), 1'b0, 64'h0, 4'(i + 1), 0, 0),
                    $sformatf("fl_push%0d", i));
        run_vec(mk(1'b1, 1'b0, 16'h0026, 9'h000, 64'h1, 1'b0, 64'h0, 4'd0, 0, 1), "flush");
        run_vec(mk(1'b0, 1'b1, 16'h0022, 9'h033, 64'h0, 1'b1, 64'h0, 4'd0, 0, 1), "fl_pop");
        run_vec(mk(1'b0, 1'b1, 16'h0024, 9'h034, 64'h0, 1'b1, 64'h0000_0008_0009_0000, 4'd0, 0, 1), "fl_status");
        run_vec(mk(1'b1, 1'b0, 16'h0026, 9'h000, 64'h3, 1'b0, 64'h0, 4'd0, 0, 1), "flush_clr");
        run_vec(mk(1'b0, 1'b1, 16'h0024, 9'h035, 64'h0, 1'b1, ST_EMPTY0, 4'd0, 0, 1), "clr_status");

        for (int i = 0; i < 3; i++)
            run_vec(mk(1'b1, 1'b0, 16'h0020, 9'h000, 64'hE0 + 64'(i), 1'b0, 64'h0, 4'(i + 1), 0, 0),
                    $sformatf("rs_push%0d", i));
        run_vec(mk(1'b0, 1'b1, 16'h0024, 9'h036, 64'h0, 1'b1, 64'h0000_0008_0000_0003, 4'd3, 0, 0), "rs_status");
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(rsp_valid),  64'd0);
        chk("midrst_count", 64'(fifo_count), 64'd0);
        chk("midrst_empty", 64'(fifo_empty), 64'd1);
        chk("midrst_data",  rsp_data,        64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(mk(1'b0, 1'b1, 16'h0040, 9'h037, 64'h0, 1'b0, 64'h0, 4'd0, 0, 1), "post_rst_oow");
        run_vec(mk(1'b0, 1'b1, 16'h0024, 9'h038, 64'h0, 1'b1, ST_EMPTY0, 4'd0, 0, 1), "post_rst_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
